// File: rtl/yolo_params_pkg.sv
// Shared sizing and state definitions for the sequential convolution window controller.
// Geometry is fixed here; conv_window_ctrl and conv_mac import it.
package yolo_params_pkg;

    localparam int IP_DATA_WIDTH = 8;
    localparam int IFMAP_SIZE    = 5;
    localparam int FILTER_SIZE   = 3;
    localparam int STRIDE        = 1;
    localparam int OFMAP_SIZE    = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1;
    localparam int ACC_WIDTH     = 2 * IP_DATA_WIDTH + $clog2(FILTER_SIZE * FILTER_SIZE);

    localparam int IF_AW  = $clog2(IFMAP_SIZE);
    localparam int FLT_AW = $clog2(FILTER_SIZE);
    localparam int OF_AW  = $clog2(OFMAP_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAST,
        OUT,
        DONE
    } conv_ctrl_state_t;

    // Ifmap coordinate of one tap: window origin plus kernel offset.
    function automatic logic [IF_AW-1:0] window_addr(input logic [OF_AW-1:0] o,
                                                     input logic [FLT_AW-1:0] k);
        return IF_AW'(o) * IF_AW'(STRIDE) + IF_AW'(k);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered unsigned multiply-accumulate: load replaces the sum, otherwise the
// product is added while en is high. Accumulator width covers a full window.
module conv_mac
    import yolo_params_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     load,
    input  logic [IP_DATA_WIDTH-1:0] a,
    input  logic [IP_DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]     acc
);

    logic [ACC_WIDTH-1:0] prod;

    assign prod = ACC_WIDTH'(a) * ACC_WIDTH'(b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= load ? prod : acc + prod;
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequential convolution scheduler: one ifmap/filter tap per cycle, one ofmap pixel per window.
// Define CONV_STALL_CNT_EN to add the stall_cnt output (cycles spent waiting on of_ready).
module conv_window_ctrl
    import yolo_params_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     if_rd_en,
    output logic [IF_AW-1:0]         if_row,
    output logic [IF_AW-1:0]         if_col,
    input  logic [IP_DATA_WIDTH-1:0] if_data,
    output logic                     flt_rd_en,
    output logic [FLT_AW-1:0]        flt_row,
    output logic [FLT_AW-1:0]        flt_col,
    input  logic [IP_DATA_WIDTH-1:0] flt_data,
    output logic                     of_valid,
    input  logic                     of_ready,
    output logic [OF_AW-1:0]         of_row,
    output logic [OF_AW-1:0]         of_col,
    output logic [ACC_WIDTH-1:0]     of_data
`ifdef CONV_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    conv_ctrl_state_t state, next_state;

    logic [OF_AW-1:0]  o_row, o_col;
    logic [FLT_AW-1:0] k_row, k_col;
    logic              issue_q, first_q;
    logic              last_tap, last_px, handshake;
    logic [ACC_WIDTH-1:0] acc;

    assign last_tap  = (k_row == FLT_AW'(FILTER_SIZE - 1)) && (k_col == FLT_AW'(FILTER_SIZE - 1));
    assign last_px   = (o_row == OF_AW'(OFMAP_SIZE - 1)) && (o_col == OF_AW'(OFMAP_SIZE - 1));
    assign handshake = (state == OUT) && of_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   if (last_tap) next_state = LAST;
            LAST:    next_state = OUT;
            OUT:     if (of_ready) next_state = last_px ? DONE : FETCH;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Kernel counters run k_col fastest; output counters advance only on a handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_row <= '0;
            o_col <= '0;
            k_row <= '0;
            k_col <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                o_row <= '0;
                o_col <= '0;
                k_row <= '0;
                k_col <= '0;
            end
        end else if (state == FETCH) begin
            if (k_col == FLT_AW'(FILTER_SIZE - 1)) begin
                k_col <= '0;
                k_row <= (k_row == FLT_AW'(FILTER_SIZE - 1)) ? '0 : k_row + 1'b1;
            end else begin
                k_col <= k_col + 1'b1;
            end
        end else if (handshake && !last_px) begin
            if (o_col == OF_AW'(OFMAP_SIZE - 1)) begin
                o_col <= '0;
                o_row <= o_row + 1'b1;
            end else begin
                o_col <= o_col + 1'b1;
            end
        end
    end

    // Read data arrives one cycle after issue, so the MAC controls are delayed to match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            issue_q <= (state == FETCH);
            first_q <= (state == FETCH) && (k_row == '0) && (k_col == '0);
        end
    end

    conv_mac u_mac (
        .clk  (clk),
        .rst  (rst),
        .en   (issue_q),
        .load (first_q),
        .a    (if_data),
        .b    (flt_data),
        .acc  (acc)
    );

    assign busy      = (state == FETCH) || (state == LAST) || (state == OUT);
    assign done      = (state == DONE);
    assign if_rd_en  = (state == FETCH);
    assign flt_rd_en = (state == FETCH);
    assign if_row    = window_addr(o_row, k_row);
    assign if_col    = window_addr(o_col, k_col);
    assign flt_row   = k_row;
    assign flt_col   = k_col;
    assign of_valid  = (state == OUT);
    assign of_row    = o_row;
    assign of_col    = o_col;
    assign of_data   = acc;

`ifdef CONV_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
        end else if ((state == OUT) && !of_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: bench-side ifmap/filter memories, a pixel
// scoreboard, and a read-address tracker. Handles CONV_STALL_CNT_EN builds too.
module tb_conv_window_ctrl;
    import yolo_params_pkg::*;

    typedef struct {
        int     row;
        int     col;
        longint data;
    } px_t;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     if_rd_en;
    logic [IF_AW-1:0]         if_row;
    logic [IF_AW-1:0]         if_col;
    logic [IP_DATA_WIDTH-1:0] if_data;
    logic                     flt_rd_en;
    logic [FLT_AW-1:0]        flt_row;
    logic [FLT_AW-1:0]        flt_col;
    logic [IP_DATA_WIDTH-1:0] flt_data;
    logic                     of_valid;
    logic                     of_ready;
    logic [OF_AW-1:0]         of_row;
    logic [OF_AW-1:0]         of_col;
    logic [ACC_WIDTH-1:0]     of_data;
`ifdef CONV_STALL_CNT_EN
    logic [15:0]              stall_cnt;
`endif

    logic [IP_DATA_WIDTH-1:0] ifmap [IFMAP_SIZE][IFMAP_SIZE];
    logic [IP_DATA_WIDTH-1:0] flt   [FILTER_SIZE][FILTER_SIZE];

    px_t sb[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  pass_no     = 0;
    int  trk_pass    = 0;
    int  trk_tap     = 0;

    conv_window_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .if_rd_en  (if_rd_en),
        .if_row    (if_row),
        .if_col    (if_col),
        .if_data   (if_data),
        .flt_rd_en (flt_rd_en),
        .flt_row   (flt_row),
        .flt_col   (flt_col),
        .flt_data  (flt_data),
        .of_valid  (of_valid),
        .of_ready  (of_ready),
        .of_row    (of_row),
        .of_col    (of_col),
        .of_data   (of_data)
`ifdef CONV_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read memories with one cycle of latency.
    always @(posedge clk) begin
        if (if_rd_en)  if_data  <= ifmap[if_row][if_col];
        if (flt_rd_en) flt_data <= flt[flt_row][flt_col];
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    function automatic longint ref_pixel(input int r, input int c);
        longint s = 0;
        for (int i = 0; i < FILTER_SIZE; i++)
            for (int j = 0; j < FILTER_SIZE; j++)
                s += longint'(ifmap[r*STRIDE+i][c*STRIDE+j]) * longint'(flt[i][j]);
        return s;
    endfunction

    task automatic push_model();
        for (int r = 0; r < OFMAP_SIZE; r++)
            for (int c = 0; c < OFMAP_SIZE; c++)
                sb.push_back('{r, c, ref_pixel(r, c)});
    endtask

    task automatic fill_mem(input bit all_ff);
        for (int r = 0; r < IFMAP_SIZE; r++)
            for (int c = 0; c < IFMAP_SIZE; c++)
                ifmap[r][c] = all_ff ? 8'hFF : IP_DATA_WIDTH'(r*IFMAP_SIZE + c + 1);
        for (int r = 0; r < FILTER_SIZE; r++)
            for (int c = 0; c < FILTER_SIZE; c++)
                flt[r][c] = all_ff ? 8'hFF : IP_DATA_WIDTH'(2);
    endtask

    // Monitor samples after the inputs driven at negedge+1 have settled.
    always @(negedge clk) begin
        #2;
        if (trk_pass != pass_no) begin
            trk_pass = pass_no;
            trk_tap  = 0;
        end
        if (rst && if_rd_en) begin
            check_output("rd_flt_en",  flt_rd_en, 1);
            check_output("rd_if_row",  if_row,
                (trk_tap / (FILTER_SIZE*FILTER_SIZE)) / OFMAP_SIZE * STRIDE + (trk_tap % (FILTER_SIZE*FILTER_SIZE)) / FILTER_SIZE);
            check_output("rd_if_col",  if_col,
                (trk_tap / (FILTER_SIZE*FILTER_SIZE)) % OFMAP_SIZE * STRIDE + (trk_tap % (FILTER_SIZE*FILTER_SIZE)) % FILTER_SIZE);
            check_output("rd_flt_row", flt_row, (trk_tap % (FILTER_SIZE*FILTER_SIZE)) / FILTER_SIZE);
            check_output("rd_flt_col", flt_col, (trk_tap % (FILTER_SIZE*FILTER_SIZE)) % FILTER_SIZE);
            trk_tap++;
        end
        if (rst && of_valid && of_ready) begin
            if (sb.size() == 0) begin
                check_output("sb_nonempty", 64'(sb.size() != 0), 1);
            end else begin
                px_t e;
                e = sb.pop_front();
                check_output("px_row",  of_row,  e.row);
                check_output("px_col",  of_col,  e.col);
                check_output("px_data", of_data, e.data);
            end
        end
    end

    // One complete pass; optional start pokes mid-pass/in DONE and a 5-cycle stall on (1,1).
    task automatic run_pass(input string tag, input bit poke, input bit stall, input int exp_cycles);
        int n         = 0;
        int left      = 5;
        bit seen      = 0;
        bit armed     = 0;
        bit chk_fetch = 0;
        pass_no++;
        start = 1;
        next_cycle();
        start = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (chk_fetch) begin
                check_output({tag, "_refetch"}, if_rd_en, 1);
                chk_fetch = 0;
            end
            if (busy || done) n++;
            if (done) begin
                seen  = 1;
                start = poke;
            end else begin
                start = poke && (i == 20 || i == 57);
                if (stall && !armed && if_rd_en && of_row == 1 && of_col == 1) begin
                    of_ready = 0;
                    armed    = 1;
                end
                if (stall && of_valid && !of_ready) begin
                    check_output({tag, "_hold_valid"}, of_valid, 1);
                    check_output({tag, "_hold_data"},  of_data,  234);
                    check_output({tag, "_hold_row"},   of_row,   1);
                    check_output({tag, "_hold_col"},   of_col,   1);
                    if (left == 0) begin
                        of_ready  = 1;
                        chk_fetch = 1;
                    end else begin
                        left--;
                    end
                end
                next_cycle();
            end
        end
        check_output({tag, "_done_seen"},    seen, 1);
        check_output({tag, "_cycles"},       n, exp_cycles);
        check_output({tag, "_busy_in_done"}, busy, 0);
`ifdef CONV_STALL_CNT_EN
        check_output({tag, "_stall_cnt"}, stall_cnt, stall ? 5 : 0);
`endif
        next_cycle();
        start    = 0;
        of_ready = 1;
        check_output({tag, "_done_pulse"}, done, 0);
        check_output({tag, "_idle_busy"},  busy, 0);
        next_cycle();
        check_output({tag, "_idle_rd"},    if_rd_en, 0);
        check_output({tag, "_idle_busy2"}, busy, 0);
        check_output({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    task automatic apply_stimulus();
        longint basic_exp [9] = '{126, 144, 162, 216, 234, 252, 306, 324, 342};
        bit found = 0;

        rst      = 0;
        start    = 0;
        of_ready = 1;
        fill_mem(0);
        #12;
        check_output("rst_busy",     busy, 0);
        check_output("rst_done",     done, 0);
        check_output("rst_if_rd_en", if_rd_en, 0);
        check_output("rst_of_valid", of_valid, 0);
        check_output("rst_of_data",  of_data, 0);
        next_cycle();
        rst = 1;
        next_cycle();

        for (int k = 0; k < 9; k++) sb.push_back('{k / 3, k % 3, basic_exp[k]});
        run_pass("basic", 0, 0, 100);

        push_model();
        run_pass("stall", 0, 1, 105);

        push_model();
        run_pass("poke", 1, 0, 100);

        // Abort a pass while pixel (0,2) is being fetched.
        push_model();
        pass_no++;
        start = 1;
        next_cycle();
        start = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (if_rd_en && of_row == 0 && of_col == 2) found = 1;
            else next_cycle();
        end
        check_output("abort_reached", found, 1);
        next_cycle();
        next_cycle();
        #2;
        rst = 0;
        #1;
        check_output("abort_busy",     busy, 0);
        check_output("abort_if_rd_en", if_rd_en, 0);
        check_output("abort_if_addr",  {if_row, if_col}, 0);
        check_output("abort_of_valid", of_valid, 0);
        check_output("abort_of_data",  of_data, 0);
        check_output("abort_sb_left",  sb.size(), 7);
        sb.delete();
        next_cycle();
        check_output("abort_no_done", done, 0);
        rst = 1;
        next_cycle();
        push_model();
        run_pass("rerun", 0, 0, 100);

        fill_mem(1);
        for (int k = 0; k < 9; k++) sb.push_back('{k / 3, k % 3, 585225});
        run_pass("ones", 0, 0, 100);
    endtask

    initial begin
        apply_stimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Sequential scheduler that runs one full convolution pass of an IFMAP_SIZE x IFMAP_SIZE ifmap against an FILTER_SIZE x FILTER_SIZE filter.
- Walks every output position, issues ifmap/filter memory reads one tap per cycle, and accumulates products in an internal MAC.
- Emits each ofmap pixel over a valid/ready handshake.
- Sits between the ifmap/filter buffers and the ofmap store; replaces the all-parallel combinational convolution where area matters.

Parameters:
- IP_DATA_WIDTH, yolo_params_pkg value, width of ifmap and filter elements (unsigned).
- IFMAP_SIZE, yolo_params_pkg value (5), ifmap side length.
- FILTER_SIZE, yolo_params_pkg value (3), filter side length.
- STRIDE, 1, window step in rows and columns.
- OFMAP_SIZE, (IFMAP_SIZE-FILTER_SIZE)/STRIDE+1, ofmap side length.
- ACC_WIDTH, 2*IP_DATA_WIDTH+$clog2(FILTER_SIZE*FILTER_SIZE), accumulator and result width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  begin a pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last ofmap handshake.
- if_rd_en  out  1  ifmap read strobe.
- if_row, if_col  out  $clog2(IFMAP_SIZE) each  ifmap read address.
- if_data  in  IP_DATA_WIDTH  ifmap read data; valid 1 cycle after if_rd_en.
- flt_rd_en  out  1  filter read strobe; always equal to if_rd_en.
- flt_row, flt_col  out  $clog2(FILTER_SIZE) each  filter read address.
- flt_data  in  IP_DATA_WIDTH  filter read data; valid 1 cycle after flt_rd_en.
- of_valid  out  1  ofmap pixel valid.
- of_ready  in  1  downstream accepts the pixel.
- of_row, of_col  out  $clog2(OFMAP_SIZE) each  ofmap pixel coordinate.
- of_data  out  ACC_WIDTH  pixel value.

Behaviour:
- Reset state: all outputs 0; FSM goes to IDLE; all counters and the accumulator are cleared. Reset mid-pass aborts the pass immediately; no done is issued.
- IDLE: start=1 moves to FETCH with o_row=o_col=k_row=k_col=0. busy rises the next cycle.
- FETCH:
  - if_rd_en=flt_rd_en=1.
  - if_row = o_row*STRIDE + k_row; if_col = o_col*STRIDE + k_col; flt_row = k_row; flt_col = k_col.
  - Kernel counters step column-major-inner (k_col fastest).
  - After tap FILTER_SIZE*FILTER_SIZE-1, go to LAST.
- MAC, in FETCH and LAST: the product of the returned data pair is accumulated one cycle after issue. The tap-0 product loads the accumulator (acc=prod); later taps add (acc+=prod). Arithmetic is unsigned full width; overflow cannot occur.
- LAST: one cycle that adds the final product, then go to OUT.
- OUT:
  - of_valid=1; of_data, of_row and of_col are registered and held stable while of_ready=0. No reads are issued.
  - Handshake when of_valid&&of_ready:
    - o_col == OFMAP_SIZE-1 and o_row == OFMAP_SIZE-1: go to DONE.
    - o_col == OFMAP_SIZE-1 otherwise: wrap o_col to 0, increment o_row, go to FETCH.
    - otherwise: increment o_col, go to FETCH.
  - of_valid drops the cycle after the handshake.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start asserted in DONE is ignored.
- start while busy is ignored. A start in IDLE on the cycle after DONE is accepted.
- Per-pixel latency with of_ready tied high: FILTER_SIZE^2 + 2 cycles. A 5x5/3x3 pass takes 9*11 = 99 cycles from FETCH entry to the last handshake; done follows on the next cycle.

Optional Feature:
- Macro: CONV_STALL_CNT_EN.
- Defined: adds output port stall_cnt (16 bits). It counts cycles in OUT with of_ready=0, clears when start is accepted, saturates at 0xFFFF, and resets to 0.
- Undefined: no port and no counter logic.

Decomposition:
- yolo_params_pkg additions:
  - OFMAP_SIZE derivation using STRIDE.
  - ACC_WIDTH.
  - Coordinate width localparams.
  - typedef enum conv_ctrl_state_t {IDLE, FETCH, LAST, OUT, DONE}.
- One sub-module, conv_mac: registered multiply-accumulate with load/enable inputs and ACC_WIDTH output.
- Address generation and the FSM stay in conv_window_ctrl.

Test Plan:
- Ifmap 1..25 row-major, filter all 2, of_ready=1 -> nine pixels in raster order: 126,144,162,216,234,252,306,324,342. Coordinates (0,0)..(2,2). done arrives 100 cycles after FETCH entry.
- of_ready held low 5 cycles on pixel (1,1) -> of_valid, of_data=234 and coordinates stay stable; the next FETCH starts the cycle after ready rises. With CONV_STALL_CNT_EN, stall_cnt=5.
- start pulsed during a pass and in DONE -> ignored; the outputs are identical to a single pass.
- rst asserted during FETCH of pixel (0,2) -> all outputs 0 asynchronously. A new start gives the full correct sequence again.
- Filter all 0xFF, ifmap all 0xFF (IP_DATA_WIDTH=8) -> every pixel is 9*65025 = 585225, with no overflow.
- Address check on pixel (2,1) -> if_row/if_col sequence (2,1),(2,2),(2,3),(3,1),...,(4,3); flt addresses (0,0)..(2,2).
